// File: rtl/minterm_scan_pkg.sv
// Shared types and constants for the minterm scan sequencer.
package minterm_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

    localparam logic [3:0] CODE_LAST = 4'd15;
    localparam int         NUM_CODES = 16;

    // Returns the table with the entry at idx replaced by bit_val.
    function automatic logic [NUM_CODES-1:0] table_set(
        input logic [NUM_CODES-1:0] tbl,
        input logic [3:0]           idx,
        input logic                 bit_val
    );
        logic [NUM_CODES-1:0] res;
        res      = tbl;
        res[idx] = bit_val;
        return res;
    endfunction

endpackage

// File: rtl/minterm_scan_ctrl_if.sv
// Bundle between the test master/evaluator and the scan controller.
interface minterm_scan_ctrl_if;
    import minterm_scan_pkg::*;

    logic                 start;
    logic                 abort;
    logic [NUM_CODES-1:0] exp_mask;
    logic                 f_in;
    logic [3:0]           code_out;
    logic                 dec_en;
    logic                 busy;
    logic                 done;
    logic                 match;
    logic [NUM_CODES-1:0] truth_table;
    logic [4:0]           ones_count;

    modport master (
        output start, abort, exp_mask, f_in,
        input  code_out, dec_en, busy, done, match, truth_table, ones_count
    );

    modport slave (
        input  start, abort, exp_mask, f_in,
        output code_out, dec_en, busy, done, match, truth_table, ones_count
    );
endinterface

// File: rtl/minterm_scan_ctrl_settle_timer.sv
// Settle timer: counts the DRIVE cycles for one code; expire marks the last one.
module scan_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int          W             = $clog2(SETTLE + 1);
    localparam logic [W-1:0] LOAD_VAL     = W'(SETTLE - 1);
    localparam logic        FIRST_EXPIRES = (SETTLE == 1);

    logic [W-1:0] cnt_r;
    logic         cnt_zero_s;

    assign cnt_zero_s = (cnt_r == {W{1'b0}});

    // Zero means "first DRIVE cycle": load the remaining count, then count down to one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clear) begin
            cnt_r <= {W{1'b0}};
        end else if (run) begin
            if (cnt_zero_s) begin
                cnt_r <= LOAD_VAL;
            end else begin
                cnt_r <= cnt_r - W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Last DRIVE cycle: immediately for SETTLE=1, otherwise when the count reaches one.
    always_comb begin
        expire = 1'b0;
        if (run) begin
            if (cnt_zero_s) begin
                expire = FIRST_EXPIRES;
            end else begin
                expire = (cnt_r == W'(1));
            end
        end else begin
            expire = 1'b0;
        end
    end
endmodule

// File: rtl/minterm_scan_ctrl.sv
// Sweeps all 16 codes of a 4-input evaluator, captures its truth table,
// counts true minterms and compares the table against a latched mask.
module minterm_scan_ctrl
    import minterm_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    minterm_scan_ctrl_if.slave  bus
);
    scan_state_e          state_r, state_nxt;
    logic                 accept_s, take_sample_s, timer_run_s, timer_clear_s, expire_s;
    logic [NUM_CODES-1:0] tt_r, tt_upd_s, mask_r;
    logic [4:0]           ones_r;
    logic [3:0]           code_r;
    logic                 dec_en_r, busy_r, done_r, match_r;

    scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .expire (expire_s)
    );

    assign timer_clear_s = (state_r != ST_DRIVE);
    assign tt_upd_s      = table_set(tt_r, code_r, bus.f_in);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode; abort wins over both start and a pending sample.
    always_comb begin
        state_nxt     = state_r;
        accept_s      = 1'b0;
        take_sample_s = 1'b0;
        timer_run_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    accept_s  = 1'b1;
                    state_nxt = ST_DRIVE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                timer_run_s = 1'b1;
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (expire_s) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    take_sample_s = 1'b1;
                    state_nxt     = (code_r == CODE_LAST) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture datapath and registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r   <= 16'h0000;
            tt_r     <= 16'h0000;
            ones_r   <= 5'd0;
            code_r   <= 4'd0;
            match_r  <= 1'b0;
            dec_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                mask_r  <= bus.exp_mask;
                tt_r    <= 16'h0000;
                ones_r  <= 5'd0;
                code_r  <= 4'd0;
                match_r <= 1'b0;
            end else if (take_sample_s) begin
                tt_r   <= tt_upd_s;
                ones_r <= ones_r + {4'd0, bus.f_in};
                if (code_r == CODE_LAST) begin
                    code_r  <= code_r;
                    match_r <= (tt_upd_s == mask_r);
                end else begin
                    code_r  <= code_r + 4'd1;
                    match_r <= 1'b0;
                end
            end
            dec_en_r <= (state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE);
            busy_r   <= (state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE);
            done_r   <= (state_nxt == ST_DONE);
        end
    end

    assign bus.code_out    = code_r;
    assign bus.dec_en      = dec_en_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.match       = match_r;
    assign bus.truth_table = tt_r;
    assign bus.ones_count  = ones_r;
endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// Self-checking bench: table-driven full scans plus abort/reset/ignored-start corners.
module tb_minterm_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fn_tbl;
    int          edge_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    minterm_scan_ctrl_if bus1();
    minterm_scan_ctrl_if bus3();

    // Evaluator: decoder4x16 ANDed with the function's minterm set, then ORed.
    assign bus1.f_in = |((bus1.dec_en ? (16'h0001 << bus1.code_out) : 16'h0000) & fn_tbl);
    assign bus3.f_in = 1'b1;

    minterm_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    minterm_scan_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    typedef struct {
        logic [15:0] mask;
        logic [15:0] fn;
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        match;
    } vec_t;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        match;
        int          start_edge;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start1(input logic [15:0] mask, output int acc_edge);
        @(negedge clk);
        bus1.exp_mask = mask;
        bus1.start    = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        acc_edge   = edge_cnt;
    endtask

    task automatic push_exp(input logic [15:0] tt, input logic [4:0] ones, input logic match, input int e);
        sb_t s;
        s.tt = tt; s.ones = ones; s.match = match; s.start_edge = e;
        sb_q.push_back(s);
    endtask

    task automatic wait_done1(input int budget, output bit ok, output int at_edge);
        ok = 1'b0;
        at_edge = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) begin
                ok = 1'b1;
                at_edge = edge_cnt;
            end
        end
    endtask

    task automatic finish_scan(input string name);
        bit  ok;
        int  at;
        sb_t s;
        wait_done1(100, ok, at);
        check({name, "_done_seen"}, {31'd0, ok}, 32'd1);
        if (sb_q.size() > 0) s = sb_q.pop_front();
        if (ok) begin
            check({name, "_latency"}, at - s.start_edge, 32'd32);
            check({name, "_tt"}, {16'd0, bus1.truth_table}, {16'd0, s.tt});
            check({name, "_ones"}, {27'd0, bus1.ones_count}, {27'd0, s.ones});
            check({name, "_match"}, {31'd0, bus1.match}, {31'd0, s.match});
            @(negedge clk);
            check({name, "_done_width"}, {31'd0, bus1.done}, 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int e;
        fn_tbl = v.fn;
        start1(v.mask, e);
        push_exp(v.tt, v.ones, v.match, e);
        finish_scan(name);
    endtask

    initial begin
        int  e, at, bad;
        bit  ok;
        vecs[0] = '{16'h28AC, 16'h28AC, 16'h28AC, 5'd6,  1'b1};
        vecs[1] = '{16'h28AD, 16'h28AC, 16'h28AC, 5'd6,  1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd16, 1'b1};
        vecs[4] = '{16'h8001, 16'h8001, 16'h8001, 5'd2,  1'b1};
        vecs[5] = '{16'h0000, 16'h8001, 16'h8001, 5'd2,  1'b0};

        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.exp_mask = 16'h0000;
        bus3.start = 1'b0; bus3.abort = 1'b0; bus3.exp_mask = 16'h0000;
        fn_tbl = 16'h28AC;

        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {bus1.code_out, bus1.dec_en, bus1.busy, bus1.done, bus1.match,
                              bus1.ones_count}, 32'd0);
        check("rst_tt", {16'd0, bus1.truth_table}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort while code 5 is being driven.
        fn_tbl = 16'h28AC;
        start1(16'h28AC, e);
        repeat (10) @(posedge clk);
        #1;
        check("abort_pre_code", {28'd0, bus1.code_out}, 32'd5);
        bus1.abort = 1'b1;
        @(posedge clk);
        #1;
        bus1.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus1.busy}, 32'd0);
        check("abort_dec_en", {31'd0, bus1.dec_en}, 32'd0);
        check("abort_tt", {16'd0, bus1.truth_table}, {16'd0, fn_tbl & 16'h001F});
        check("abort_ones", {27'd0, bus1.ones_count}, $countones(fn_tbl & 16'h001F));
        check("abort_match", {31'd0, bus1.match}, 32'd0);
        wait_done1(40, ok, at);
        check("abort_no_done", {31'd0, ok}, 32'd0);

        // Start re-pulsed mid-scan must be ignored, including its mask.
        start1(16'h28AC, e);
        push_exp(16'h28AC, 5'd6, 1'b1, e);
        repeat (14) @(posedge clk);
        #1;
        check("restart_code", {28'd0, bus1.code_out}, 32'd7);
        bus1.start    = 1'b1;
        bus1.exp_mask = 16'h0000;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        finish_scan("restart");

        // Start together with abort in IDLE stays idle.
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        @(negedge clk);
        check("startabort_busy", {31'd0, bus1.busy}, 32'd0);
        wait_done1(40, ok, at);
        check("startabort_no_done", {31'd0, ok}, 32'd0);

        // Asynchronous reset in the middle of code 9.
        start1(16'h28AC, e);
        repeat (18) @(posedge clk);
        #1;
        check("rst_mid_code", {28'd0, bus1.code_out}, 32'd9);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {bus1.code_out, bus1.dec_en, bus1.busy, bus1.done, bus1.match,
                                  bus1.ones_count}, 32'd0);
        check("rst_mid_tt", {16'd0, bus1.truth_table}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "after_rst");

        // SETTLE=3 instance with f_in tied high: each code held four cycles.
        @(negedge clk);
        bus3.exp_mask = 16'hFFFF;
        bus3.start    = 1'b1;
        @(posedge clk);
        #1;
        bus3.start = 1'b0;
        e   = edge_cnt;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus3.code_out !== 4'(k / 4)) bad++;
            if (bus3.done !== 1'b0) bad++;
        end
        check("s3_hold", bad, 32'd0);
        @(negedge clk);
        check("s3_done", {31'd0, bus3.done}, 32'd1);
        check("s3_latency", edge_cnt - e, 32'd64);
        check("s3_tt", {16'd0, bus3.truth_table}, 32'h0000FFFF);
        check("s3_ones", {27'd0, bus3.ones_count}, 32'd16);
        check("s3_match", {31'd0, bus3.match}, 32'd1);
        @(negedge clk);
        check("s3_done_width", {31'd0, bus3.done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/minterm_scan_ctrl.md
Name: minterm_scan_ctrl

Overview:
Sequencer that sweeps all 16 input codes of a 4-input decoder-based function block (decoder4x16 plus OR), one code at a time. It captures the function output into a 16-bit truth table, counts the true minterms and compares the table against an expected mask. It sits between a test/configuration master (start/abort handshake) and the combinational evaluator (code_out/dec_en out, f_in back).

Parameters:
SETTLE, 1, cycles code_out is held before f_in is sampled (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
abort  input  1  terminate the scan and return to IDLE; priority over start
exp_mask  input  16  expected truth table; latched when start is accepted
f_in  input  1  function output from the evaluator for the current code_out
code_out  output  4  code driven to the evaluator as {a,b,c,d}, MSB = a
dec_en  output  1  decoder enable; high only in DRIVE and SAMPLE
busy  output  1  high in DRIVE and SAMPLE
done  output  1  single-cycle pulse when a full scan completes
match  output  1  truth_table == latched exp_mask; valid from done, held until next accepted start
truth_table  output  16  bit i = f_in sampled for code i
ones_count  output  5  number of set bits captured, 0..16

Behaviour:
- Reset (async, rst_n=0): state IDLE; code_out=0, dec_en=0, busy=0, done=0, match=0, truth_table=0, ones_count=0, settle counter=0, latched mask=0. Reset mid-scan takes effect immediately; no done pulse.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 and abort=0 -> latch exp_mask; clear truth_table, ones_count and match; code_out=0; settle counter=0; go to DRIVE.
- DRIVE: dec_en=1, code_out stable. Stay SETTLE cycles, then go to SAMPLE.
- SAMPLE: one cycle, code_out unchanged. At the edge, truth_table[code_out] <= f_in and ones_count += f_in.
  - code_out==15 -> go to DONE.
  - Otherwise code_out+1, settle counter cleared, go to DRIVE.
- DONE: one cycle. done=1, dec_en=0, match=(truth_table==latched mask). Then go to IDLE. code_out stays 15 until the next start.
- Latency: done is high in the cycle that begins 16*(SETTLE+1) rising edges after the edge that accepted start. SETTLE=1 gives 32 edges.
- abort=1 in DRIVE or SAMPLE: at the next edge go to IDLE, dec_en=0, no done pulse, match=0. A sample scheduled on that edge is discarded. truth_table and ones_count keep their partial values.
- abort in IDLE or DONE: no effect, except that it blocks start in the same cycle. In DONE the done pulse still completes.
- start while busy or in DONE: ignored, not queued.
- Width: ones_count is 5 bits and cannot overflow (maximum 16). code_out does not wrap; the SAMPLE at code 15 always exits to DONE.

Decomposition:
- Shared package minterm_scan_pkg holds:
  - state encoding for IDLE/DRIVE/SAMPLE/DONE (2-bit);
  - CODE_LAST = 4'd15;
  - NUM_CODES = 16.
- One sub-module, scan_settle_timer: a loadable down-counter of width $clog2(SETTLE+1) with clear and expire outputs, used by DRIVE.
- Evaluator (function4x1) is instantiated only in the bench and the top level, not inside this block.

Test Plan:
- Prime function, SETTLE=1, exp_mask=16'h28AC, pulse start -> truth_table=16'h28AC, ones_count=6, match=1; done exactly 32 edges after start edge, one cycle wide.
- Same DUT, exp_mask=16'h28AD -> truth_table=16'h28AC, ones_count=6, match=0, done pulses once.
- SETTLE=3, f_in tied 1, exp_mask=16'hFFFF -> truth_table=16'hFFFF, ones_count=16, match=1, done at edge 64; each code held 4 cycles.
- Abort while code_out=5 in DRIVE -> next edge IDLE, busy=0, dec_en=0, no done, truth_table bits 0..4 only, match=0.
- start re-pulsed at code 7, and start+abort together in IDLE -> scan unaffected and completes normally; simultaneous case stays IDLE.
- rst_n low for one cycle mid-scan at code 9 -> all outputs zero asynchronously; a fresh start then completes a full scan.
